// File: rtl/axi_slave_push_fsm.sv
// rtl/axi_slave_push_fsm.sv - P2A completion consumer: B responses and R beat slicing
// Multi-chunk read completions are fetched one DATA_WIDTH chunk at a time.
package axi_slave_package;
   typedef enum logic [1:0] {
      CPL_NONE = 2'b00,
      CPL_WR   = 2'b01,
      CPL_RD   = 2'b10,
      CPL_ERR  = 2'b11
   } cpl_t;
endpackage

module axi_slave_push_fsm
   import axi_slave_package::*;
#(
   parameter int DATA_WIDTH     = 1024,
   parameter int AXI_DATA_WIDTH = 256
) (
   input  logic                      ACLK,
   input  logic                      ARESETn,
   input  cpl_t                      Cpl_Type,
   input  logic [9:0]                Cpl_Length,
   input  logic [DATA_WIDTH-1:0]     Cpl_Data,
   output logic                      Cpl_Grant,
   output logic                      Cpl_Command,
   input  logic                      b_full,
   output logic                      b_push,
   output logic [1:0]                b_resp,
   input  logic                      r_full,
   output logic                      r_push,
   output logic [AXI_DATA_WIDTH-1:0] r_data,
   output logic [1:0]                r_resp,
   output logic                      r_last
);

   localparam int BEATS  = DATA_WIDTH / AXI_DATA_WIDTH;
   localparam int LANES  = AXI_DATA_WIDTH / 32;
   localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int REM_W  = 11;
   localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(BEATS - 1);
   localparam logic [REM_W-1:0]  BEAT_DW   = REM_W'(LANES);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      R_PUSH  = 2'b01,
      R_FETCH = 2'b10
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   chunk_reg_q, chunk_reg_d;
   logic [REM_W-1:0]        remaining_q, remaining_d;
   logic [BIDX_W-1:0]       beat_idx_q, beat_idx_d;
   logic [AXI_DATA_WIDTH-1:0] beat_data;
   logic                    final_beat;

   assign Cpl_Command = (state_q == R_FETCH);
   assign final_beat  = (remaining_q <= BEAT_DW);

   // Lanes past the end of the completion read as zero on the tail beat.
   always_comb begin
      beat_data = chunk_reg_q[beat_idx_q*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
      for (int j = 0; j < LANES; j++) begin
         if (REM_W'(j) >= remaining_q) begin
            beat_data[j*32 +: 32] = '0;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      chunk_reg_d = chunk_reg_q;
      remaining_d = remaining_q;
      beat_idx_d  = beat_idx_q;
      Cpl_Grant   = 1'b0;
      b_push      = 1'b0;
      b_resp      = 2'b00;
      r_push      = 1'b0;
      r_data      = '0;
      r_resp      = 2'b00;
      r_last      = 1'b0;
      // Strobes are held low while reset is asserted, even with a header presented.
      if (ARESETn) begin
         case (state_q)
            IDLE: begin
               case (Cpl_Type)
                  CPL_WR: begin
                     if (!b_full) begin
                        b_push    = 1'b1;
                        Cpl_Grant = 1'b1;
                     end
                  end
                  CPL_ERR: begin
                     if (!r_full) begin
                        r_push    = 1'b1;
                        r_resp    = 2'b10;
                        r_last    = 1'b1;
                        Cpl_Grant = 1'b1;
                     end
                  end
                  CPL_RD: begin
                     Cpl_Grant   = 1'b1;
                     chunk_reg_d = Cpl_Data;
                     remaining_d = (Cpl_Length == 10'd0) ? 11'd1024 : {1'b0, Cpl_Length};
                     beat_idx_d  = '0;
                     state_d     = R_PUSH;
                  end
                  default: ;
               endcase
            end
            R_PUSH: begin
               if (!r_full) begin
                  r_push      = 1'b1;
                  r_data      = beat_data;
                  r_last      = final_beat;
                  remaining_d = final_beat ? '0 : (remaining_q - BEAT_DW);
                  beat_idx_d  = (beat_idx_q == LAST_BEAT) ? '0 : (beat_idx_q + 1'b1);
                  if (final_beat) begin
                     state_d = IDLE;
                  end else if (beat_idx_q == LAST_BEAT) begin
                     state_d = R_FETCH;
                  end
               end
            end
            R_FETCH: begin
               if (Cpl_Type == CPL_RD) begin
                  Cpl_Grant   = 1'b1;
                  chunk_reg_d = Cpl_Data;
                  state_d     = R_PUSH;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q     <= IDLE;
         chunk_reg_q <= '0;
         remaining_q <= '0;
         beat_idx_q  <= '0;
      end else begin
         state_q     <= state_d;
         chunk_reg_q <= chunk_reg_d;
         remaining_q <= remaining_d;
         beat_idx_q  <= beat_idx_d;
      end
   end

endmodule

// File: tb/tb_axi_slave_push_fsm.sv
// tb/tb_axi_slave_push_fsm.sv - directed bench for axi_slave_push_fsm
module tb_axi_slave_push_fsm;
   import axi_slave_package::*;

   logic          ACLK = 1'b0;
   logic          ARESETn;
   cpl_t          Cpl_Type;
   logic [9:0]    Cpl_Length;
   logic [1023:0] Cpl_Data;
   logic          Cpl_Grant, Cpl_Command;
   logic          b_full, b_push;
   logic [1:0]    b_resp;
   logic          r_full, r_push, r_last;
   logic [255:0]  r_data;
   logic [1:0]    r_resp;

   int checks = 0;
   int failures = 0;

   always #5 ACLK = ~ACLK;

   axi_slave_push_fsm #(.DATA_WIDTH(1024), .AXI_DATA_WIDTH(256)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn), .Cpl_Type(Cpl_Type), .Cpl_Length(Cpl_Length),
      .Cpl_Data(Cpl_Data), .Cpl_Grant(Cpl_Grant), .Cpl_Command(Cpl_Command),
      .b_full(b_full), .b_push(b_push), .b_resp(b_resp), .r_full(r_full),
      .r_push(r_push), .r_data(r_data), .r_resp(r_resp), .r_last(r_last)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1023:0] mk_chunk(input int c);
      logic [1023:0] d;
      for (int i = 0; i < 32; i++) d[i*32 +: 32] = 32'(c*32 + i);
      return d;
   endfunction

   function automatic logic [255:0] exp_beat(input int b, input int eff);
      logic [255:0] e;
      for (int j = 0; j < 8; j++) e[j*32 +: 32] = (b*8 + j < eff) ? 32'(b*8 + j) : 32'd0;
      return e;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_grant"}, 256'(Cpl_Grant), 256'd0);
      chk({tag, "_cmd"},   256'(Cpl_Command), 256'd0);
      chk({tag, "_bpush"}, 256'(b_push), 256'd0);
      chk({tag, "_bresp"}, 256'(b_resp), 256'd0);
      chk({tag, "_rpush"}, 256'(r_push), 256'd0);
      chk({tag, "_rdata"}, r_data, 256'd0);
      chk({tag, "_rresp"}, 256'(r_resp), 256'd0);
      chk({tag, "_rlast"}, 256'(r_last), 256'd0);
   endtask

   // Header, then one model-driven cycle per loop; abort_at >= 0 stops after that many beats.
   task automatic do_read(input string tag, input int len, input bit rnd, input int abort_at);
      int eff, nbeats, nchunks, beat, fetched, lasts, cyc, budget;
      bit pending, present, exp_push;
      eff = (len == 0) ? 1024 : len;
      nbeats = (eff + 7) / 8;
      nchunks = (eff + 31) / 32;
      beat = 0; fetched = 0; lasts = 0; cyc = 0; pending = 0;
      budget = nbeats * 6 + 40;
      @(negedge ACLK);
      r_full = 1'b0; Cpl_Type = CPL_RD; Cpl_Length = 10'(len); Cpl_Data = mk_chunk(0);
      #1;
      chk({tag, "_hdr_grant"}, 256'(Cpl_Grant), 256'd1);
      chk({tag, "_hdr_cmd"}, 256'(Cpl_Command), 256'd0);
      chk({tag, "_hdr_rpush"}, 256'(r_push), 256'd0);
      @(posedge ACLK);
      while (beat < nbeats && beat != abort_at && cyc < budget) begin
         @(negedge ACLK);
         r_full = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
         present = pending && (!rnd || $urandom_range(0, 1) == 1);
         Cpl_Type = present ? CPL_RD : CPL_NONE;
         Cpl_Length = 10'd0;
         Cpl_Data = mk_chunk(fetched + 1);
         exp_push = !pending && !r_full;
         #1;
         chk({tag, "_cmd"}, 256'(Cpl_Command), 256'(pending));
         chk({tag, "_grant"}, 256'(Cpl_Grant), 256'(present));
         chk({tag, "_rpush"}, 256'(r_push), 256'(exp_push));
         if (exp_push) begin
            chk({tag, "_rdata"}, r_data, exp_beat(beat, eff));
            chk({tag, "_rlast"}, 256'(r_last), 256'(beat == nbeats - 1));
            chk({tag, "_rresp"}, 256'(r_resp), 256'd0);
            if (r_last) lasts++;
         end
         @(posedge ACLK);
         cyc++;
         if (present) begin
            pending = 0;
            fetched++;
         end
         if (exp_push) begin
            beat++;
            if (beat % 4 == 0 && beat < nbeats) pending = 1;
         end
      end
      chk({tag, "_budget"}, 256'(cyc < budget), 256'd1);
      if (abort_at < 0) begin
         @(negedge ACLK);
         Cpl_Type = CPL_NONE; r_full = 1'b0;
         #1;
         chk({tag, "_end_rpush"}, 256'(r_push), 256'd0);
         chk({tag, "_end_cmd"}, 256'(Cpl_Command), 256'd0);
         chk({tag, "_fetches"}, 256'(fetched), 256'(nchunks - 1));
         chk({tag, "_lasts"}, 256'(lasts), 256'd1);
      end
   endtask

   initial begin
      ARESETn = 1'b0; Cpl_Type = CPL_NONE; Cpl_Length = '0; Cpl_Data = '0;
      b_full = 1'b0; r_full = 1'b0;
      repeat (2) @(negedge ACLK);
      #1;
      chk_all_zero("reset");
      @(negedge ACLK);
      ARESETn = 1'b1;

      // Write response, same-cycle push and grant.
      @(negedge ACLK);
      Cpl_Type = CPL_WR; b_full = 1'b0;
      #1;
      chk("wr_bpush", 256'(b_push), 256'd1);
      chk("wr_bresp", 256'(b_resp), 256'd0);
      chk("wr_grant", 256'(Cpl_Grant), 256'd1);
      chk("wr_rpush", 256'(r_push), 256'd0);

      // Write held back by a full B FIFO.
      for (int i = 0; i < 3; i++) begin
         @(negedge ACLK);
         Cpl_Type = CPL_WR; b_full = 1'b1;
         #1;
         chk("wrfull_grant", 256'(Cpl_Grant), 256'd0);
         chk("wrfull_bpush", 256'(b_push), 256'd0);
      end
      @(negedge ACLK);
      b_full = 1'b0;
      #1;
      chk("wrrel_grant", 256'(Cpl_Grant), 256'd1);
      chk("wrrel_bpush", 256'(b_push), 256'd1);
      @(negedge ACLK);
      Cpl_Type = CPL_NONE;
      #1;
      chk("wrdone_bpush", 256'(b_push), 256'd0);

      do_read("rd20", 20, 1'b0, -1);
      do_read("rd40", 40, 1'b0, -1);
      do_read("rd1024", 0, 1'b0, -1);

      // Error completion, first stalled by r_full.
      @(negedge ACLK);
      Cpl_Type = CPL_ERR; r_full = 1'b1;
      #1;
      chk("errfull_grant", 256'(Cpl_Grant), 256'd0);
      chk("errfull_rpush", 256'(r_push), 256'd0);
      @(negedge ACLK);
      r_full = 1'b0;
      #1;
      chk("err_grant", 256'(Cpl_Grant), 256'd1);
      chk("err_rpush", 256'(r_push), 256'd1);
      chk("err_rresp", 256'(r_resp), 256'd2);
      chk("err_rlast", 256'(r_last), 256'd1);
      chk("err_rdata", r_data, 256'd0);
      @(negedge ACLK);
      Cpl_Type = CPL_NONE;

      do_read("rd40rnd", 40, 1'b1, -1);

      // Reset in the middle of a burst.
      do_read("rdabort", 40, 1'b0, 2);
      @(negedge ACLK);
      Cpl_Type = CPL_NONE; r_full = 1'b0;
      ARESETn = 1'b0;
      #1;
      chk_all_zero("midreset");
      @(negedge ACLK);
      ARESETn = 1'b1;
      @(negedge ACLK);
      #1;
      chk("postrst_rpush", 256'(r_push), 256'd0);
      chk("postrst_cmd", 256'(Cpl_Command), 256'd0);
      @(negedge ACLK);
      Cpl_Type = CPL_WR; b_full = 1'b0;
      #1;
      chk("postrst_wr_bpush", 256'(b_push), 256'd1);
      chk("postrst_wr_grant", 256'(Cpl_Grant), 256'd1);
      chk("postrst_wr_rpush", 256'(r_push), 256'd0);
      @(negedge ACLK);
      Cpl_Type = CPL_NONE;

      do_read("rd20b", 20, 1'b0, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi_slave_push_fsm.md
# axi_slave_push_fsm

Completion push FSM of the AXI slave bridge: consumer end of the P2A completion handshake. It accepts completions from the P2A mapper (type, length, up to DATA_WIDTH bits of payload per chunk), emits AXI write responses into the B FIFO, and slices read payload into AXI R beats (RDATA/RRESP/RLAST) pushed into the R FIFO. Multi-chunk read completions are fetched chunk by chunk with Cpl_Command.

## Interface
- DATA_WIDTH, 1024, width of Cpl_Data (one P2A chunk; 32 DW)
- AXI_DATA_WIDTH, 256, RDATA width (8 DW per beat); DATA_WIDTH must be an integer multiple
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- Cpl_Type  in  cpl_t (2)  from axi_slave_package: 2'b00 CPL_NONE, 2'b01 CPL_WR, 2'b10 CPL_RD, 2'b11 CPL_ERR
- Cpl_Length  in  10  completion length in DW; 0 encodes 1024
- Cpl_Data  in  DATA_WIDTH  payload chunk, DW0 in bits [31:0]
- Cpl_Grant  out  1  completion/chunk consumed this cycle
- Cpl_Command  out  1  1 = deliver next data chunk only (no header); 0 = header phase
- b_full  in  1  B FIFO full
- b_push  out  1  B FIFO write strobe
- b_resp  out  2  BRESP
- r_full  in  1  R FIFO full
- r_push  out  1  R FIFO write strobe
- r_data  out  AXI_DATA_WIDTH  RDATA
- r_resp  out  2  RRESP
- r_last  out  1  RLAST

## Operation
- States: IDLE, R_PUSH, R_FETCH. Cpl_Command = (state == R_FETCH), Moore.
- Registers: chunk_reg (DATA_WIDTH), remaining (11 bits, DW), beat_idx ($clog2(DATA_WIDTH/AXI_DATA_WIDTH) bits).
- IDLE:
  - CPL_NONE: nothing.
  - CPL_WR: if !b_full, b_push=1, b_resp=2'b00, Cpl_Grant=1; stay IDLE. If b_full, no grant; P2A holds.
  - CPL_ERR: if !r_full, one R beat: r_data=0, r_resp=2'b10 (SLVERR), r_last=1, Cpl_Grant=1; stay IDLE. Else hold.
  - CPL_RD: Cpl_Grant=1 unconditionally; chunk_reg<=Cpl_Data, remaining<=(Cpl_Length==0)?1024:Cpl_Length, beat_idx<=0; -> R_PUSH.
- R_PUSH, per cycle with !r_full:
  - r_push=1, r_data=chunk_reg[beat_idx*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] with DW lanes >= remaining zeroed, r_resp=2'b00, r_last=(remaining<=8).
  - remaining <= remaining - min(8, remaining); beat_idx++.
  - remaining<=8 -> IDLE; else if beat_idx is last of chunk -> R_FETCH (beat_idx wraps to 0); else stay.
  - r_full=1: no push, state/counters frozen.
- R_FETCH: waits for Cpl_Type==CPL_RD (data-chunk valid); Cpl_Grant=1, chunk_reg<=Cpl_Data, Cpl_Length ignored; -> R_PUSH. Other types ignored, no grant.
- Cpl_Grant is combinational; asserted only in the cycle data is consumed. Outputs b_push/r_push/r_data/r_resp/r_last/b_resp combinational from state/regs; all zero when not pushing.

## Timing
- Reset (async assert, any state): state=IDLE, remaining=0, beat_idx=0, chunk_reg=0; all outputs 0 (Cpl_Grant, Cpl_Command, b_push, b_resp, r_push, r_data, r_resp, r_last).
- B response: push and grant in the same cycle the CPL_WR is presented (0-cycle latency when !b_full).
- Read: grant at cycle N, first r_push at N+1 (if !r_full); one beat per cycle thereafter.
- Chunk boundary: last beat of chunk at M, Cpl_Command=1 from M+1; chunk granted at K>=M+1; next beat at K+1. One bubble minimum per chunk.
- Read completion of L DW: ceil(L/8) beats, exactly one with r_last=1 (the final one).
- Reset mid-transfer: partial burst abandoned, no further pushes; next accepted header restarts cleanly.

## Test plan
- CPL_WR with b_full=0 -> b_push=1, b_resp=00, Cpl_Grant=1 same cycle; with b_full=1 for 3 cycles -> no grant until b_full drops, then single push.
- CPL_RD, Cpl_Length=20, Cpl_Data DW i = i -> 3 beats: DW0-7, DW8-15, DW16-19 with DW lanes 4-7 zero and r_last=1 on beat 3 only; back to IDLE.
- CPL_RD, Cpl_Length=40 -> 4 beats, Cpl_Command=1, second chunk granted, 1 beat with r_last=1; exactly 5 r_push total.
- CPL_RD, Cpl_Length=0 -> 128 beats across 32 chunks, 31 R_FETCH grants, r_last only on beat 128.
- r_full toggled randomly during 40-DW read -> no dropped/duplicated beats, data order preserved; CPL_ERR -> one beat r_resp=10, r_last=1, r_data=0.
- ARESETn asserted after beat 2 of a 40-DW read -> all outputs 0 immediately; new CPL_WR after release handled normally.
